step_sched: RTL
===============

# step_sched

Request scheduler for the shared lab counter register. Four sources compete for one WIDTH-bit counter: debounced manual step pulses, an internal auto-tick timer, a clear request and a switch-load request. The block latches each request, grants at most one per cycle by fixed priority plus round-robin between the two step sources, and applies the granted operation. It sits between the button debouncers and the hex decoders / LED outputs.

## Interface
- WIDTH, 8: counter width in bits
- TICK_DIV, 100_000_000: auto-tick period in clk100_i cycles (≥2)
- clk100_i  in  1  system clock, 100 MHz
- rstn_i  in  1  asynchronous reset, active-low
- manual_req_i  in  1  single-cycle step pulse from debouncer
- clr_req_i  in  1  single-cycle clear pulse
- load_req_i  in  1  single-cycle load pulse
- load_val_i  in  WIDTH  value captured with load_req_i
- auto_en_i  in  1  level; enables auto-tick timer
- dir_i  in  1  step direction: 0 up, 1 down; sampled at grant
- cnt_o  out  WIDTH  counter value (registered)
- grant_o  out  4  one-hot registered grant {clr, load, auto, manual}
- wrap_o  out  1  one-cycle pulse when a step wrapped
- overrun_o  out  1  one-cycle pulse when a request hit an already-pending flag
- busy_o  out  1  any request pending

## Operation
- Pending flags p_clr, p_load, p_auto, p_man; load value held in a WIDTH-bit register, captured on load_req_i.
- Request pulse sets its flag at the sampling edge. Pulse while flag already set and not being granted that cycle: request dropped, overrun_o pulses next cycle, p_load keeps first-captured value.
- Arbitration each cycle over current flags: p_clr > p_load > {p_auto, p_man}. Auto vs manual: round-robin pointer; if both pending, serve the source not served last; pointer updates on every step grant; reset value favours manual.
- Grant actions: clr → cnt 0, also clears p_auto, p_man, p_load; load → cnt = held value; step → cnt ± 1 mod 2^WIDTH per dir_i.
- Granted flag clears at grant edge; a new pulse for the same source in that same cycle re-sets it (no overrun).
- wrap_o: up from 2^WIDTH−1 to 0, or down from 0 to 2^WIDTH−1; never on clr/load.
- Auto timer: divider counts 0..TICK_DIV−1 while auto_en_i=1; at TICK_DIV−1 sets p_auto (overrun rule applies) and restarts at 0. auto_en_i=0: divider held at 0, p_auto cleared. Clear grant also restarts divider at 0.
- busy_o = OR of pending flags (combinational from registers).

## Timing
- Reset (rstn_i low, any time): cnt_o=0, grant_o=0, wrap_o=0, overrun_o=0, busy_o=0, all flags, divider, held value and pointer=0; mid-operation requests lost.
- Latency: pulse sampled at edge k → flag set after k → grant at edge k+1 → cnt_o, grant_o, wrap_o valid in cycle after k+1 (one-cycle grant latency when uncontested).
- grant_o and wrap_o high exactly one cycle, coincident with the new cnt_o.
- Throughput: one grant per cycle; N simultaneously pending requests drain in N cycles (clr flushes others in one).
- Simultaneous clr and load pulses: clr granted first, flushes p_load set same edge? No — flush covers flags pending before the clr grant edge only; a load pulse sampled on the clr grant edge survives and is granted next.

## Test plan
- WIDTH=8, TICK_DIV=4, cnt=0, dir=0: manual pulse → one cycle later cnt_o=1, grant_o=0001, busy_o low afterwards.
- cnt=8'hFF via load (load_val=8'hFF), manual pulse with dir=0 → cnt_o=0, wrap_o=1; repeat with cnt=0, dir=1 → cnt_o=8'hFF, wrap_o=1.
- auto_en_i=1 for 12 cycles, no other input → cnt_o increments to 3, grant_o=0010 every 4th cycle; deassert → divider frozen, no further grants.
- manual and auto pending in same cycle, pointer at manual-last → auto granted first, manual next cycle; cnt +2 total over 2 cycles.
- clr, load(8'h5A), manual pulsed same cycle with cnt=8'h10 → grant 1000, cnt=0, load and manual flushed, no further grants; then second manual pulse while p_man set → overrun_o pulse, single increment only.
- rstn_i low during pending load and auto → all outputs 0 immediately, no grant after release.

Source files
------------

// File: rtl/step_sched.sv
// Request scheduler for the shared lab counter: latches clear/load/auto/manual
// requests, grants one per cycle (clr > load > round-robin auto/manual) and applies it.
module step_sched #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk100_i,
    input  logic             rstn_i,
    input  logic             manual_req_i,
    input  logic             clr_req_i,
    input  logic             load_req_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [3:0]       grant_o,
    output logic             wrap_o,
    output logic             overrun_o,
    output logic             busy_o
);
    localparam int               DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d, held_q, held_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       grant_q, gnt;
    logic             wrap_q, wrap_d, ovr_q, ovr_d;
    logic             p_clr_q, p_clr_d, p_load_q, p_load_d;
    logic             p_auto_q, p_auto_d, p_man_q, p_man_d;
    logic             last_man_q, last_man_d;
    logic             step, tick;
    logic             keep_clr, keep_load, keep_auto, keep_man;

    // Fixed priority, round-robin only between the two step sources.
    always_comb begin
        gnt = 4'b0000;
        if (p_clr_q)                     gnt[3] = 1'b1;
        else if (p_load_q)               gnt[2] = 1'b1;
        else if (p_auto_q && p_man_q) begin
            if (last_man_q)              gnt[1] = 1'b1;
            else                         gnt[0] = 1'b1;
        end
        else if (p_auto_q)               gnt[1] = 1'b1;
        else if (p_man_q)                gnt[0] = 1'b1;
    end

    assign step = gnt[1] | gnt[0];
    assign tick = auto_en_i && (div_q == DIV_LAST);

    // A flag survives the edge only if it is neither granted nor flushed by clr.
    assign keep_clr  = p_clr_q  & ~gnt[3];
    assign keep_load = p_load_q & ~gnt[2] & ~gnt[3];
    assign keep_auto = p_auto_q & ~gnt[1] & ~gnt[3] & auto_en_i;
    assign keep_man  = p_man_q  & ~gnt[0] & ~gnt[3];

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (gnt[3]) begin
            cnt_d = '0;
        end else if (gnt[2]) begin
            cnt_d = held_q;
        end else if (step) begin
            cnt_d  = dir_i ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
            wrap_d = dir_i ? (cnt_q == '0) : (cnt_q == CNT_MAX);
        end
    end

    always_comb begin
        p_clr_d    = keep_clr  | clr_req_i;
        p_load_d   = keep_load | load_req_i;
        p_auto_d   = keep_auto | tick;
        p_man_d    = keep_man  | manual_req_i;
        ovr_d      = (clr_req_i & keep_clr) | (load_req_i & keep_load)
                   | (tick & keep_auto)     | (manual_req_i & keep_man);
        held_d     = (load_req_i && !keep_load) ? load_val_i : held_q;
        last_man_d = step ? gnt[0] : last_man_q;
        if (!auto_en_i || gnt[3] || div_q == DIV_LAST) div_d = '0;
        else                                           div_d = div_q + 1'b1;
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q      <= '0;
            held_q     <= '0;
            div_q      <= '0;
            grant_q    <= 4'b0000;
            wrap_q     <= 1'b0;
            ovr_q      <= 1'b0;
            p_clr_q    <= 1'b0;
            p_load_q   <= 1'b0;
            p_auto_q   <= 1'b0;
            p_man_q    <= 1'b0;
            last_man_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            div_q      <= div_d;
            grant_q    <= gnt;
            wrap_q     <= wrap_d;
            ovr_q      <= ovr_d;
            p_clr_q    <= p_clr_d;
            p_load_q   <= p_load_d;
            p_auto_q   <= p_auto_d;
            p_man_q    <= p_man_d;
            last_man_q <= last_man_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign grant_o   = grant_q;
    assign wrap_o    = wrap_q;
    assign overrun_o = ovr_q;
    assign busy_o    = p_clr_q | p_load_q | p_auto_q | p_man_q;
endmodule
